// File: rtl/ldpc_iter_ctrl.sv
// Frame-level iteration controller for the flooding LDPC decoder: clear, iterate, capture, hand off.
// Optional statistics counters are enabled with `define LDPC_STATS_EN.
module ldpc_iter_ctrl #(
  parameter int R        = 24,
  parameter int D        = 96,
  parameter int ITER_W   = 6,
  parameter int MAX_ITER = 32,
  parameter int STAT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                in_ready,
  input  logic [ITER_W-1:0]   cfg_max_iter,
  input  logic                abort,
  output logic                dp_rst,
  output logic                dp_en,
  input  logic                syn_ok,
  input  logic [R*D-1:0]      dec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [R*D-1:0]      res,
  output logic                err,
`ifdef LDPC_STATS_EN
  output logic [ITER_W-1:0]   iters,
  output logic [STAT_W-1:0]   stat_frames,
  output logic [STAT_W-1:0]   stat_fails
`else
  output logic [ITER_W-1:0]   iters
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

  localparam logic [ITER_W-1:0] LP_MAX = ITER_W'(MAX_ITER);

  state_t              r_state, w_next;
  logic [ITER_W-1:0]   r_limit, r_cnt;
  logic [ITER_W-1:0]   w_limit, w_cnt_p1;
  logic                w_accept, w_capture, w_fail;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_fail    = 1'b0;
    w_cnt_p1  = r_cnt + 1'b1;
    w_limit   = (cfg_max_iter == '0 || cfg_max_iter > LP_MAX) ? LP_MAX : cfg_max_iter;
    in_ready  = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
    w_accept  = start && in_ready;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CLR;
      S_CLR:  w_next = S_RUN;
      S_RUN: begin
        // abort outranks a same-cycle syndrome hit or limit hit
        if (abort) begin
          w_next = S_IDLE;
        end else if (syn_ok) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (w_cnt_p1 == r_limit) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
          w_fail    = 1'b1;
        end
      end
      S_DONE: if (out_ready) w_next = w_accept ? S_CLR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_limit <= '0;
      r_cnt   <= '0;
      res     <= '0;
      err     <= 1'b0;
      iters   <= '0;
    end else begin
      if (w_accept) begin
        r_limit <= w_limit;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt   <= w_cnt_p1;
      end
      if (w_capture) begin
        res   <= dec;
        err   <= w_fail;
        iters <= w_cnt_p1;
      end
    end
  end

  assign dp_rst    = (r_state == S_CLR);
  assign dp_en     = (r_state == S_RUN);
  assign out_valid = (r_state == S_DONE);

`ifdef LDPC_STATS_EN
  // saturating counters, bumped on every entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_fails  <= '0;
    end else if (w_capture) begin
      if (stat_frames != '1)          stat_frames <= stat_frames + 1'b1;
      if (w_fail && stat_fails != '1) stat_fails  <= stat_fails + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed self-checking bench for ldpc_iter_ctrl (default build, feature macro undefined).
module tb_ldpc_iter_ctrl;
  localparam int R = 24, D = 96, W = R*D, ITER_W = 6;

  logic              clk = 1'b0;
  logic              rst, start, abort, syn_ok, out_ready;
  logic [ITER_W-1:0] cfg_max_iter;
  logic [W-1:0]      dec;
  logic              in_ready, dp_rst, dp_en, out_valid, err;
  logic [W-1:0]      res;
  logic [ITER_W-1:0] iters;

  int n_chk = 0;
  int n_fail = 0;

  ldpc_iter_ctrl #(.R(R), .D(D), .ITER_W(ITER_W), .MAX_ITER(32), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .cfg_max_iter(cfg_max_iter),
    .abort(abort), .dp_rst(dp_rst), .dp_en(dp_en), .syn_ok(syn_ok), .dec(dec),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .err(err), .iters(iters)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input logic [31:0] s);
    return {72{s}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; start = 0; abort = 0; syn_ok = 0; out_ready = 0; cfg_max_iter = '0; dec = '0;
    tick; tick;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_chk++; if (dp_en !== 1'b0) begin n_fail++; $display("FAIL reset_dp_en got %b exp 0", dp_en); end
    n_chk++; if (dp_rst !== 1'b0) begin n_fail++; $display("FAIL reset_dp_rst got %b exp 0", dp_rst); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    n_chk++; if (iters !== 6'd0) begin n_fail++; $display("FAIL reset_iters got %0d exp 0", iters); end
    n_chk++; if (res !== '0) begin n_fail++; $display("FAIL reset_res got %h exp 0", res[63:0]); end
    rst = 0;
    tick;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_early_term;
    cfg_max_iter = 6'd10; start = 1; dec = pat(32'h1111_0000);
    tick;
    n_chk++; if (dp_rst !== 1'b1 || dp_en !== 1'b0) begin n_fail++; $display("FAIL early_clr got rst=%b en=%b exp rst=1 en=0", dp_rst, dp_en); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL early_clr_in_ready got %b exp 0", in_ready); end
    start = 0;
    tick; dec = pat(32'h1111_0001);
    n_chk++; if (dp_en !== 1'b1 || dp_rst !== 1'b0) begin n_fail++; $display("FAIL early_run1 got en=%b rst=%b exp en=1 rst=0", dp_en, dp_rst); end
    tick; dec = pat(32'h1111_0002);
    tick; dec = pat(32'h1234_ABCD); syn_ok = 1;
    tick; syn_ok = 0; dec = pat(32'hDEAD_0000);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL early_out_valid got %b exp 1", out_valid); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL early_err got %b exp 0", err); end
    n_chk++; if (iters !== 6'd3) begin n_fail++; $display("FAIL early_iters got %0d exp 3", iters); end
    n_chk++; if (res !== pat(32'h1234_ABCD)) begin n_fail++; $display("FAIL early_res got %h exp %h", res[63:0], 64'h1234ABCD1234ABCD); end
    n_chk++; if (dp_en !== 1'b0) begin n_fail++; $display("FAIL early_done_dp_en got %b exp 0", dp_en); end
    out_ready = 1;
    tick; out_ready = 0;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL early_idle got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_limit(input logic [ITER_W-1:0] cfg, input int exp);
    int n_en;
    logic seen;
    n_en = 0; seen = 0;
    cfg_max_iter = cfg; start = 1; dec = pat({26'h0, cfg});
    tick; start = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick;
      if (dp_en) n_en++;
      if (out_valid) seen = 1;
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL limit_timeout cfg=%0d got no out_valid exp out_valid", cfg); end
    n_chk++; if (n_en != exp) begin n_fail++; $display("FAIL limit_run_cycles cfg=%0d got %0d exp %0d", cfg, n_en, exp); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL limit_err cfg=%0d got %b exp 1", cfg, err); end
    n_chk++; if (iters !== 6'(exp)) begin n_fail++; $display("FAIL limit_iters cfg=%0d got %0d exp %0d", cfg, iters, exp); end
    n_chk++; if (res !== pat({26'h0, cfg})) begin n_fail++; $display("FAIL limit_res cfg=%0d got %h", cfg, res[63:0]); end
    out_ready = 1;
    tick; out_ready = 0;
  endtask

  task automatic test_back_to_back;
    int n_en;
    logic seen;
    cfg_max_iter = 6'd4; start = 1; dec = pat(32'hCAFE_0004);
    tick; start = 0;
    for (int i = 0; i < 100 && !out_valid; i++) tick;
    n_chk++; if (out_valid !== 1'b1 || iters !== 6'd4 || err !== 1'b1) begin n_fail++; $display("FAIL b2b_first got v=%b iters=%0d err=%b exp v=1 iters=4 err=1", out_valid, iters, err); end
    for (int k = 0; k < 7; k++) begin
      dec = pat(32'h5555_0000 + k); abort = (k == 3);
      tick;
      n_chk++; if (out_valid !== 1'b1 || res !== pat(32'hCAFE_0004) || err !== 1'b1 || iters !== 6'd4) begin
        n_fail++; $display("FAIL b2b_hold k=%0d got v=%b res=%h err=%b iters=%0d exp v=1 res=cafe0004 err=1 iters=4", k, out_valid, res[63:0], err, iters);
      end
    end
    abort = 0;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_stalled got %b exp 0", in_ready); end
    out_ready = 1; start = 1; cfg_max_iter = 6'd2; dec = pat(32'h0B0B_0002);
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    tick; out_ready = 0; start = 0;
    n_chk++; if (dp_rst !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_clr got rst=%b v=%b exp rst=1 v=0", dp_rst, out_valid); end
    n_en = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick;
      if (dp_en) n_en++;
      if (out_valid) seen = 1;
    end
    n_chk++; if (!seen || n_en != 2 || iters !== 6'd2 || err !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got seen=%b runs=%0d iters=%0d err=%b exp seen=1 runs=2 iters=2 err=1", seen, n_en, iters, err);
    end
    out_ready = 1;
    tick; out_ready = 0;
  endtask

  task automatic test_abort;
    int n_v;
    n_v = 0;
    cfg_max_iter = 6'd10; start = 1; dec = pat(32'hAB0A_0000);
    tick; start = 0;
    tick; tick;
    start = 1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_run_in_ready got %b exp 0", in_ready); end
    tick; start = 0;
    tick; abort = 1;
    n_chk++; if (dp_en !== 1'b1) begin n_fail++; $display("FAIL abort_run4_dp_en got %b exp 1", dp_en); end
    tick; abort = 0;
    n_chk++; if (dp_en !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got en=%b rdy=%b v=%b exp en=0 rdy=1 v=0", dp_en, in_ready, out_valid);
    end
    n_chk++; if (iters !== 6'd2 || err !== 1'b1 || res !== pat(32'h0B0B_0002)) begin
      n_fail++; $display("FAIL abort_results_kept got iters=%0d err=%b res=%h exp iters=2 err=1 res=0b0b0002", iters, err, res[63:0]);
    end
    for (int i = 0; i < 12; i++) begin
      tick;
      if (out_valid || dp_rst || dp_en) n_v++;
    end
    n_chk++; if (n_v != 0) begin n_fail++; $display("FAIL abort_quiet got %0d active cycles exp 0", n_v); end
  endtask

  task automatic test_reset_mid;
    cfg_max_iter = 6'd10; start = 1; dec = pat(32'h7777_0000);
    tick; start = 0;
    tick; tick;
    rst = 1;
    tick; rst = 0;
    n_chk++; if (dp_en !== 1'b0 || dp_rst !== 1'b0 || out_valid !== 1'b0 || iters !== 6'd0 || err !== 1'b0 || res !== '0) begin
      n_fail++; $display("FAIL rst_run got en=%b rst=%b v=%b iters=%0d err=%b res=%h exp all 0", dp_en, dp_rst, out_valid, iters, err, res[63:0]);
    end
    cfg_max_iter = 6'd1; start = 1; dec = pat(32'h8888_0001);
    tick; start = 0;
    tick; tick;
    n_chk++; if (out_valid !== 1'b1 || iters !== 6'd1 || err !== 1'b1 || res !== pat(32'h8888_0001)) begin
      n_fail++; $display("FAIL rst_prep_done got v=%b iters=%0d err=%b exp v=1 iters=1 err=1", out_valid, iters, err);
    end
    rst = 1;
    tick; rst = 0;
    n_chk++; if (out_valid !== 1'b0 || iters !== 6'd0 || err !== 1'b0 || res !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_done got v=%b iters=%0d err=%b res=%h rdy=%b exp 0/0/0/0/1", out_valid, iters, err, res[63:0], in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_early_term;
    test_limit(6'd5, 5);
    test_limit(6'd1, 1);
    test_limit(6'd0, 32);
    test_limit(6'd40, 32);
    test_limit(6'd32, 32);
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
